// File: rtl/riscv_pkg.sv
// Shared encodings for the writeback stage: result-select codes, load funct3
// values and the default datapath width.
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_ILL  = 2'b11
  } result_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB bundle: the retiring instruction and pipeline controls coming in,
// the register-file write port, the bypass copy and status going out.
interface wb_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic            stall;
  logic            flush;
  logic            in_valid;
  logic            in_reg_write;
  logic [4:0]      in_wr;
  logic [1:0]      in_result_sel;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_mem_rdata;
  logic [XLEN-1:0] in_pc_plus4;
  logic [2:0]      in_funct3;

  logic            RegWrite;
  logic [4:0]      wr;
  logic [XLEN-1:0] wd;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            misalign;
  logic [CNT_W-1:0] instret;

  // Upstream side (MEM stage / bench): drives the instruction, sees results.
  modport master (
    output stall, flush, in_valid, in_reg_write, in_wr, in_result_sel,
           in_alu_result, in_mem_rdata, in_pc_plus4, in_funct3,
    input  RegWrite, wr, wd, fwd_valid, fwd_rd, fwd_data, misalign, instret
  );

  // Stage side.
  modport slave (
    input  stall, flush, in_valid, in_reg_write, in_wr, in_result_sel,
           in_alu_result, in_mem_rdata, in_pc_plus4, in_funct3,
    output RegWrite, wr, wd, fwd_valid, fwd_rd, fwd_data, misalign, instret
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Load lane selection and sign/zero extension of the raw aligned memory word,
// plus detection of misaligned or undefined load encodings.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            bad_load
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed byte and halfword lanes out of the word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    byte_v = rdata[7:0];
    case (offset)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected lane by load type; flag unaligned or unknown loads.
  always_comb begin
    data     = '0;
    bad_load = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH: begin
        data     = {{(XLEN-16){half_v[15]}}, half_v};
        bad_load = offset[0];
      end
      F3_LHU: begin
        data     = {{(XLEN-16){1'b0}}, half_v};
        bad_load = offset[0];
      end
      F3_LW: begin
        data     = rdata;
        bad_load = (offset != 2'd0);
      end
      default: bad_load = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with writeback source select, load extension,
// x0 write suppression, a forwarding copy for EX and a retired counter.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int CNT_W     = 64,
  parameter bit X0_FILTER = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_stage_if.slave   bus
);

  logic [XLEN-1:0] load_data;
  logic            load_bad;
  logic            bad_d;
  logic            x0_hit;
  logic            we_d;
  logic [XLEN-1:0] wd_d;
  logic            valid_q;
  result_sel_e     sel;

  assign sel = result_sel_e'(bus.in_result_sel);

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata    (bus.in_mem_rdata),
    .offset   (bus.in_alu_result[1:0]),
    .funct3   (bus.in_funct3),
    .data     (load_data),
    .bad_load (load_bad)
  );

  // Decide the write enable and the writeback value for the incoming instruction.
  always_comb begin
    bad_d  = (sel == RES_ILL) || ((sel == RES_LOAD) && load_bad);
    x0_hit = X0_FILTER && (bus.in_wr == 5'd0);
    we_d   = bus.in_valid && bus.in_reg_write && !x0_hit && !bad_d;
    case (sel)
      RES_LOAD: wd_d = load_data;
      RES_PC4:  wd_d = bus.in_pc_plus4;
      default:  wd_d = bus.in_alu_result;
    endcase
  end

  // Pipeline register: flush beats stall beats normal capture. wr/wd only move
  // together with a write so the register file never sees data change idly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      bus.RegWrite <= 1'b0;
      bus.wr       <= '0;
      bus.wd       <= '0;
      bus.misalign <= 1'b0;
      bus.instret  <= '0;
    end else if (bus.flush) begin
      // NOTE: state is written with <= so every register samples the
      // pre-edge values, independent of statement order.
      valid_q      <= 1'b0;
      bus.RegWrite <= 1'b0;
      bus.misalign <= 1'b0;
    end else if (bus.stall) begin
      bus.RegWrite <= 1'b0;
    end else begin
      valid_q      <= bus.in_valid;
      bus.RegWrite <= we_d;
      bus.misalign <= bus.in_valid && bad_d;
      if (we_d) begin
        bus.wr <= bus.in_wr;
        bus.wd <= wd_d;
      end
      if (bus.in_valid) bus.instret <= bus.instret + CNT_W'(1);
    end
  end

  // Bypass entry is the registered write port itself.
  assign bus.fwd_valid = bus.RegWrite;
  assign bus.fwd_rd    = bus.wr;
  assign bus.fwd_data  = bus.wd;

  // A write can only come from a captured valid instruction.
  a_write_has_valid: assert property (
    @(posedge clk) disable iff (!rst_n) bus.RegWrite |-> valid_q
  );

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic, directly upstream of the register file.
- Captures the retiring instruction's results, selects the writeback source and sign/zero-extends load data.
- Drives RegWrite/wr/wd into the register file and exports a forwarding copy for the EX bypass.
- Keeps a retired-instruction counter.

Parameters:
XLEN, 32, datapath width
CNT_W, 64, width of retired-instruction counter
X0_FILTER, 1, when 1 writes targeting x0 are suppressed

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold stage, do not capture inputs
flush  in  1  discard incoming instruction (capture as bubble)
in_valid  in  1  incoming instruction valid
in_reg_write  in  1  instruction writes a destination register
in_wr  in  5  destination register number
in_result_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved
in_alu_result  in  XLEN  ALU result / effective address
in_mem_rdata  in  XLEN  raw aligned word from data memory
in_pc_plus4  in  XLEN  link value for jal/jalr
in_funct3  in  3  load type
RegWrite  out  1  register-file write enable
wr  out  5  register-file write address
wd  out  XLEN  register-file write data
fwd_valid  out  1  forwarding entry valid (equals RegWrite)
fwd_rd  out  5  forwarding destination (equals wr)
fwd_data  out  XLEN  forwarding data (equals wd)
misalign  out  1  registered: captured load was misaligned or illegal
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n low, async): RegWrite=0, wr=0, wd=0, misalign=0, instret=0, internal valid=0. Reset mid-operation drops any pending write.
- Latency: one cycle. Inputs present at edge N appear on RegWrite/wr/wd after edge N.
- Capture priority per edge: flush > stall > normal.
  - flush=1: stage becomes a bubble. RegWrite=0, misalign=0, wr/wd hold previous values. No instret increment.
  - stall=1 (flush=0): RegWrite forced 0 (the held instruction already wrote), wr/wd/misalign hold. No increment.
  - normal: valid_q = in_valid. RegWrite = in_valid & in_reg_write & ~(X0_FILTER & in_wr==0) & ~bad_load.
- Update timing: wr, wd and RegWrite update on the same edge. When the new RegWrite is 0, wd and wr hold their previous values, so the register file never sees a data change without a write.
- Result select: 00 -> alu_result; 01 -> extended load; 10 -> pc_plus4; 11 -> treated as illegal (no write, misalign=1).
- Load extension: byte offset = alu_result[1:0].
  - funct3 000 lb: byte lane offset, sign-extended.
  - 100 lbu: same byte lane, zero-extended.
  - 001 lh: halfword at offset 0 or 2, sign-extended.
  - 101 lhu: same halfword, zero-extended.
  - 010 lw: offset must be 0.
- bad_load (result_sel=01 only): lh/lhu with offset 1 or 3; lw with offset not 0; funct3 011/110/111. Effect: RegWrite=0, misalign=1 for that cycle. The instruction still counts as retired.
- instret: +1 on each normal-capture edge with in_valid=1. Wraps modulo 2^CNT_W silently.
- Forwarding outputs are pure copies of the registered outputs; no extra latency.
- x0 filter: in_wr=0 with X0_FILTER=1 gives RegWrite=0 and wd unchanged.

Decomposition:
- Shared package riscv_pkg:
  - RES_ALU/RES_LOAD/RES_PC4 encodings for result_sel.
  - F3_LB/LH/LW/LBU/LHU funct3 constants.
  - XLEN default.
- One natural sub-module: load_align. Combinational; inputs rdata, offset, funct3; outputs extended data and bad_load.

Test Plan:
- Reset: assert rst_n=0 mid-stream with RegWrite=1 -> all outputs 0 immediately, instret=0.
- ALU write: in_valid=1, reg_write=1, wr=7, sel=00, alu=0x0000_1234 -> next cycle RegWrite=1, wr=7, wd=0x1234, instret=1.
- Loads, rdata=0x8877_F180:
  - lb offset 0 -> wd=0xFFFF_FF80.
  - lbu offset 1 -> wd=0x0000_00F1.
  - lh offset 2 -> wd=0xFFFF_8877.
  - lhu offset 0 -> wd=0x0000_F180.
- Misaligned: lw offset 2 -> RegWrite=0, misalign=1, wd unchanged, instret still increments. lh offset 3 -> same response.
- x0 and link: wr=0, alu=0xDEAD -> RegWrite=0, wd holds. Then sel=10, pc_plus4=0x104, wr=1 -> wd=0x104, RegWrite=1.
- Stall/flush: stall=1 for 3 cycles after a write to x5 -> RegWrite=0, wr=5 and wd held, instret frozen. flush=1 together with stall=1 -> bubble, valid cleared, no increment.
